ttc_counter_lite14: RTL and testbench
=====================================

TTC_COUNTER_LITE14 -- requirements
Module: ttc_counter_lite14

Interface
REQ-001 SHALL have port pclk14, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port n_p_reset14, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port pwdata14, input, 16, write data.
REQ-004 SHALL have port cntr_ctrl_reg_sel14, input, 1, control write strobe; pwdata14[4:0] is captured.
REQ-005 SHALL have port interval_reg_sel14, input, 1, interval register write strobe.
REQ-006 SHALL have ports match_1_reg_sel14, match_2_reg_sel14 and match_3_reg_sel14, input, 1 each, match register write strobes.
REQ-007 SHALL have port clk_ctrl_en14, input, 1, prescaled count tick, one pclk14 wide.
REQ-008 SHALL have port counter_val14, output, 16, current count.
REQ-009 SHALL have port cntr_ctrl_out14, output, 5, control register readback; bit4 always reads 0.
REQ-010 SHALL have ports interval_intr14, overflow_intr14 and restart14, output, 1 each, registered one-cycle pulses.
REQ-011 SHALL have port match_intr14, output, [3:1], registered one-cycle pulses.

Function
REQ-012 SHALL define control bits: [0] disable (1 = stopped), [1] interval mode, [2] decrement, [3] match enable, [4] counter reset (self-clearing, not stored).
REQ-013 SHALL advance the counter only in cycles where clk_ctrl_en14=1 and disable=0; otherwise hold.
REQ-014 SHALL, in increment non-interval mode, wrap 16'hFFFF -> 0 on tick and pulse overflow_intr14.
REQ-015 SHALL, in increment interval mode, load 0 on a tick where counter >= interval and pulse interval_intr14; this covers an interval lowered while running.
REQ-016 SHALL, in decrement non-interval mode, wrap 0 -> 16'hFFFF on tick and pulse overflow_intr14.
REQ-017 SHALL, in decrement interval mode, load the interval value on a tick at 0 and pulse interval_intr14.
REQ-018 SHALL, with interval=0 in interval mode, hold counter at 0 and pulse interval_intr14 on every tick.
REQ-019 SHALL never pulse overflow_intr14 in interval mode.
REQ-020 SHALL, when match enable=1, pulse match_intr14[n] in the same cycle counter_val14 first shows a new value equal to match_n register; no pulse while the counter holds.
REQ-021 SHALL, on a control write with pwdata14[4]=1, load 0 (increment) or interval / 16'hFFFF (decrement, interval / non-interval) in the next cycle and pulse restart14 for one cycle.
REQ-022 SHALL give counter reset priority over a simultaneous tick; no interval, overflow or match pulse that cycle.
REQ-023 SHALL use old control bits for a tick coinciding with a control write; new bits apply from the next cycle.
REQ-024 SHALL apply interval and match writes to the comparison in the cycle after the write.
REQ-025 SHALL allow pulses on consecutive cycles when clk_ctrl_en14 is held high.

Reset
REQ-026 SHALL, on n_p_reset14 low, immediately clear counter_val14, interval register, match registers, all pulse outputs, and control bits [3:1].
REQ-027 SHALL reset control bit0 to 1, so cntr_ctrl_out14 = 5'b00001.
REQ-028 SHALL produce no pulses in the first cycle after reset release.

Structure
REQ-029 SHALL place in package ttc_lite_pkg14: counter width (16), control width (5), control bit index constants, and 16'hFFFF max constant.
REQ-030 SHALL instantiate sub-module ttc_match_cmp14 three times, one per match register: holds register, compares next count, registers the pulse.

Verification
REQ-031 SHALL cover: reset, enable increment, tick every cycle -> count 0,1,2...; at 16'hFFFF next tick gives 0 and overflow_intr14 for one cycle.
REQ-032 SHALL cover: interval=5, interval mode, increment -> sequence 0..5,0, interval_intr14 on the wrap cycle, no overflow_intr14.
REQ-033 SHALL cover: decrement interval mode, interval=3 -> 3,2,1,0,3, interval_intr14 on the reload.
REQ-034 SHALL cover: match_2=7, match enable, increment -> match_intr14[2] pulses once when count shows 7; tick stopped at 7 -> no repeat.
REQ-035 SHALL cover: counter reset write coinciding with a tick at count 0x1234 -> count 0, restart14 pulse, no other pulse.
REQ-036 SHALL cover: assert n_p_reset14 mid-count -> outputs cleared asynchronously, cntr_ctrl_out14=5'b00001.

Source files
------------

// File: rtl/ttc_lite_pkg14.sv
// Shared widths, control-bit positions and helpers for the lite timer/counter.
package ttc_lite_pkg14;

  localparam int CNT_W  = 16;
  localparam int CTRL_W = 5;

  localparam int CTRL_DISABLE  = 0;
  localparam int CTRL_INTERVAL = 1;
  localparam int CTRL_DEC      = 2;
  localparam int CTRL_MATCH    = 3;
  localparam int CTRL_RESTART  = 4;

  typedef logic [CNT_W-1:0] count_t;

  localparam count_t CNT_MAX  = 16'hFFFF;
  localparam count_t CNT_ZERO = 16'h0000;
  localparam count_t CNT_ONE  = 16'h0001;

  // Value the counter restarts from for a given direction and mode.
  function automatic count_t restart_value(input logic dec, input logic interval_mode,
                                           input count_t interval);
    if (!dec)
      return CNT_ZERO;
    else if (interval_mode)
      return interval;
    else
      return CNT_MAX;
  endfunction

endpackage

// File: rtl/ttc_match_cmp14.sv
// One match channel: holds its match value and pulses when an advancing
// count lands on it.
module ttc_match_cmp14
  import ttc_lite_pkg14::*;
(
  input  logic   pclk14,
  input  logic   n_p_reset14,
  input  logic   wr_sel,
  input  count_t wr_data,
  input  logic   enable,
  input  logic   advance,
  input  count_t cur_count,
  input  count_t next_count,
  output logic   match_pulse
);

  count_t match_reg;

  // Compare against the value about to be shown so the pulse lines up with it;
  // a count that does not change is not a new arrival.
  always_ff @(posedge pclk14 or negedge n_p_reset14) begin
    if (!n_p_reset14) begin
      match_reg   <= CNT_ZERO;
      match_pulse <= 1'b0;
    end else begin
      if (wr_sel)
        match_reg <= wr_data;
      match_pulse <= enable && advance && (next_count != cur_count) &&
                     (next_count == match_reg);
    end
  end

endmodule

// File: rtl/ttc_counter_lite14.sv
// Lite 16-bit timer/counter: up/down, free-running or interval, three match
// channels and a self-clearing restart.
module ttc_counter_lite14
  import ttc_lite_pkg14::*;
(
  input  logic              pclk14,
  input  logic              n_p_reset14,
  input  logic [CNT_W-1:0]  pwdata14,
  input  logic              cntr_ctrl_reg_sel14,
  input  logic              interval_reg_sel14,
  input  logic              match_1_reg_sel14,
  input  logic              match_2_reg_sel14,
  input  logic              match_3_reg_sel14,
  input  logic              clk_ctrl_en14,
  output logic [CNT_W-1:0]  counter_val14,
  output logic [CTRL_W-1:0] cntr_ctrl_out14,
  output logic              interval_intr14,
  output logic              overflow_intr14,
  output logic              restart14,
  output logic [3:1]        match_intr14
);

  logic [CTRL_W-2:0] ctrl_reg;
  count_t            interval_reg;
  count_t            next_count;
  logic              hit_interval;
  logic              hit_overflow;
  logic              restart_req;
  logic              advance;
  logic [3:1]        match_sel;

  assign cntr_ctrl_out14 = {1'b0, ctrl_reg};
  assign restart_req     = cntr_ctrl_reg_sel14 && pwdata14[CTRL_RESTART];
  assign advance         = clk_ctrl_en14 && !ctrl_reg[CTRL_DISABLE] && !restart_req;
  assign match_sel       = {match_3_reg_sel14, match_2_reg_sel14, match_1_reg_sel14};

  // ">=" in up/interval mode also catches an interval lowered below the count.
  always_comb begin
    next_count   = counter_val14;
    hit_interval = 1'b0;
    hit_overflow = 1'b0;
    if (!ctrl_reg[CTRL_DEC]) begin
      if (ctrl_reg[CTRL_INTERVAL]) begin
        if (counter_val14 >= interval_reg) begin
          next_count   = CNT_ZERO;
          hit_interval = 1'b1;
        end else begin
          next_count = counter_val14 + CNT_ONE;
        end
      end else begin
        next_count   = counter_val14 + CNT_ONE;
        hit_overflow = (counter_val14 == CNT_MAX);
      end
    end else begin
      if (ctrl_reg[CTRL_INTERVAL]) begin
        if (counter_val14 == CNT_ZERO) begin
          next_count   = interval_reg;
          hit_interval = 1'b1;
        end else begin
          next_count = counter_val14 - CNT_ONE;
        end
      end else begin
        next_count   = counter_val14 - CNT_ONE;
        hit_overflow = (counter_val14 == CNT_ZERO);
      end
    end
  end

  // Restart takes the freshly written direction/mode; a tick uses the old bits.
  always_ff @(posedge pclk14 or negedge n_p_reset14) begin
    if (!n_p_reset14) begin
      counter_val14   <= CNT_ZERO;
      ctrl_reg        <= 4'b0001;
      interval_reg    <= CNT_ZERO;
      interval_intr14 <= 1'b0;
      overflow_intr14 <= 1'b0;
      restart14       <= 1'b0;
    end else begin
      interval_intr14 <= 1'b0;
      overflow_intr14 <= 1'b0;
      restart14       <= 1'b0;
      if (restart_req) begin
        counter_val14 <= restart_value(pwdata14[CTRL_DEC], pwdata14[CTRL_INTERVAL],
                                       interval_reg);
        restart14     <= 1'b1;
      end else if (advance) begin
        counter_val14   <= next_count;
        interval_intr14 <= hit_interval;
        overflow_intr14 <= hit_overflow;
      end
      if (cntr_ctrl_reg_sel14)
        ctrl_reg <= pwdata14[CTRL_W-2:0];
      if (interval_reg_sel14)
        interval_reg <= pwdata14;
    end
  end

  for (genvar n = 1; n <= 3; n++) begin : g_match
    ttc_match_cmp14 u_match (
      .pclk14      (pclk14),
      .n_p_reset14 (n_p_reset14),
      .wr_sel      (match_sel[n]),
      .wr_data     (pwdata14),
      .enable      (ctrl_reg[CTRL_MATCH]),
      .advance     (advance),
      .cur_count   (counter_val14),
      .next_count  (next_count),
      .match_pulse (match_intr14[n])
    );
  end

endmodule

// File: tb/tb_ttc_counter_lite14.sv
// Self-checking bench: directed scenarios plus random traffic against an
// arithmetic reference model of the counter.
module tb_ttc_counter_lite14;

  logic        pclk14;
  logic        n_p_reset14;
  logic [15:0] pwdata14;
  logic        cntr_ctrl_reg_sel14;
  logic        interval_reg_sel14;
  logic        match_1_reg_sel14;
  logic        match_2_reg_sel14;
  logic        match_3_reg_sel14;
  logic        clk_ctrl_en14;
  logic [15:0] counter_val14;
  logic [4:0]  cntr_ctrl_out14;
  logic        interval_intr14;
  logic        overflow_intr14;
  logic        restart14;
  logic [3:1]  match_intr14;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_cnt;
  logic [3:0] m_ctrl;
  int         m_intv;
  int         m_match [1:3];
  logic [5:0] m_pulses;

  ttc_counter_lite14 dut (
    .pclk14              (pclk14),
    .n_p_reset14         (n_p_reset14),
    .pwdata14            (pwdata14),
    .cntr_ctrl_reg_sel14 (cntr_ctrl_reg_sel14),
    .interval_reg_sel14  (interval_reg_sel14),
    .match_1_reg_sel14   (match_1_reg_sel14),
    .match_2_reg_sel14   (match_2_reg_sel14),
    .match_3_reg_sel14   (match_3_reg_sel14),
    .clk_ctrl_en14       (clk_ctrl_en14),
    .counter_val14       (counter_val14),
    .cntr_ctrl_out14     (cntr_ctrl_out14),
    .interval_intr14     (interval_intr14),
    .overflow_intr14     (overflow_intr14),
    .restart14           (restart14),
    .match_intr14        (match_intr14)
  );

  initial pclk14 = 1'b0;
  always #5 pclk14 = ~pclk14;

  function automatic logic [5:0] dut_pulses();
    return {restart14, overflow_intr14, interval_intr14, match_intr14};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_ctrl   = 4'b0001;
    m_intv   = 0;
    m_pulses = '0;
    for (int n = 1; n <= 3; n++) m_match[n] = 0;
  endtask

  // One clock of the specified behaviour, using the inputs currently applied.
  task automatic model_step();
    bit rst_req, adv;
    int nxt;
    m_pulses = '0;
    rst_req  = cntr_ctrl_reg_sel14 && pwdata14[4];
    adv      = clk_ctrl_en14 && !m_ctrl[0] && !rst_req;
    if (rst_req) begin
      m_cnt       = !pwdata14[2] ? 0 : (pwdata14[1] ? m_intv : 65535);
      m_pulses[5] = 1'b1;
    end else if (adv) begin
      nxt = m_cnt;
      if (!m_ctrl[2]) begin
        if (m_ctrl[1]) begin
          if (m_cnt >= m_intv) begin nxt = 0; m_pulses[3] = 1'b1; end
          else nxt = m_cnt + 1;
        end else begin
          nxt = (m_cnt + 1) % 65536;
          m_pulses[4] = (m_cnt == 65535);
        end
      end else begin
        if (m_ctrl[1]) begin
          if (m_cnt == 0) begin nxt = m_intv; m_pulses[3] = 1'b1; end
          else nxt = m_cnt - 1;
        end else begin
          nxt = (m_cnt + 65535) % 65536;
          m_pulses[4] = (m_cnt == 0);
        end
      end
      if (m_ctrl[3] && nxt != m_cnt)
        for (int n = 1; n <= 3; n++)
          if (nxt == m_match[n]) m_pulses[n-1] = 1'b1;
      m_cnt = nxt;
    end
    if (cntr_ctrl_reg_sel14) m_ctrl = pwdata14[3:0];
    if (interval_reg_sel14)  m_intv = int'(pwdata14);
    if (match_1_reg_sel14)   m_match[1] = int'(pwdata14);
    if (match_2_reg_sel14)   m_match[2] = int'(pwdata14);
    if (match_3_reg_sel14)   m_match[3] = int'(pwdata14);
  endtask

  task automatic applyStimulus(input logic csel, input logic isel, input logic [3:1] msel,
                               input logic tick, input logic [15:0] data);
    cntr_ctrl_reg_sel14 = csel;
    interval_reg_sel14  = isel;
    match_1_reg_sel14   = msel[1];
    match_2_reg_sel14   = msel[2];
    match_3_reg_sel14   = msel[3];
    clk_ctrl_en14       = tick;
    pwdata14            = data;
    @(posedge pclk14);
    #1;
    model_step();
    checkOutput("count", 32'(counter_val14), 32'(m_cnt));
    checkOutput("ctrl_out", 32'(cntr_ctrl_out14), 32'({1'b0, m_ctrl}));
    checkOutput("pulses", 32'(dut_pulses()), 32'(m_pulses));
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1, 16'h0);
  endtask

  initial begin
    logic [15:0] data;
    logic [3:1]  msel;
    int          seq32 [6];
    int          seq33 [4];
    seq32 = '{1, 2, 3, 4, 5, 0};
    seq33 = '{2, 1, 0, 3};

    n_p_reset14 = 1'b0;
    applyStimulusIdle();
    model_reset();
    #23;
    checkOutput("reset_count", 32'(counter_val14), 32'h0);
    checkOutput("reset_ctrl", 32'(cntr_ctrl_out14), 32'h1);
    checkOutput("reset_pulses", 32'(dut_pulses()), 32'h0);
    @(posedge pclk14);
    #1 n_p_reset14 = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1, 16'h0);
    checkOutput("post_reset_quiet", 32'(dut_pulses()), 32'h0);

    // Free-running increment, then force FFFF via a down restart and wrap up.
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      tick_n(1);
      checkOutput("inc_seq", 32'(counter_val14), 32'(i));
    end
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 16'h0014);
    checkOutput("dec_restart_max", 32'(counter_val14), 32'hFFFF);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 16'h0000);
    tick_n(1);
    checkOutput("wrap_count", 32'(counter_val14), 32'h0);
    checkOutput("wrap_ovf", 32'(overflow_intr14), 32'h1);
    tick_n(1);
    checkOutput("ovf_one_cycle", 32'(overflow_intr14), 32'h0);

    // Up interval mode, interval 5.
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 16'd5);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 16'h0012);
    checkOutput("intv_start", 32'(counter_val14), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick_n(1);
      checkOutput("intv_up_seq", 32'(counter_val14), 32'(seq32[i]));
      checkOutput("intv_up_irq", 32'(interval_intr14), 32'(i == 5));
      checkOutput("intv_up_no_ovf", 32'(overflow_intr14), 32'h0);
    end

    // Down interval mode, interval 3.
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 16'd3);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 16'h0016);
    checkOutput("intv_dn_start", 32'(counter_val14), 32'h3);
    for (int i = 0; i < 4; i++) begin
      tick_n(1);
      checkOutput("intv_dn_seq", 32'(counter_val14), 32'(seq33[i]));
      checkOutput("intv_dn_irq", 32'(interval_intr14), 32'(i == 3));
    end

    // Match channel 2 at 7, then hold the count there.
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 16'd7);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 16'h0018);
    for (int i = 1; i <= 7; i++) begin
      tick_n(1);
      checkOutput("match2", 32'(match_intr14), (i == 7) ? 32'h2 : 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 16'h0);
      checkOutput("match2_hold", 32'(match_intr14), 32'h0);
    end

    // Restart colliding with a tick at 0x1234 that would otherwise match.
    applyStimulus(1'b0, 1'b1, 3'b001, 1'b0, 16'h1234);
    applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 16'h1233);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 16'h001E);
    checkOutput("at_1234", 32'(counter_val14), 32'h1234);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b1, 16'h0010);
    checkOutput("restart_count", 32'(counter_val14), 32'h0);
    checkOutput("restart_pulses", 32'(dut_pulses()), 32'h20);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      data = ($urandom % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 30));
      msel = 3'b000;
      if ($urandom % 10 == 0) msel = 3'($urandom);
      if ($urandom % 12 == 0) begin
        data[0] = ($urandom % 4 == 0);
        applyStimulus(1'b1, 1'b0, msel, 1'($urandom % 10 < 7), data);
      end else begin
        applyStimulus(1'b0, ($urandom % 15 == 0), msel, 1'($urandom % 10 < 7), data);
      end
    end

    // Asynchronous reset in the middle of counting.
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 16'h0010);
    tick_n(9);
    #2 n_p_reset14 = 1'b0;
    #1;
    checkOutput("async_count", 32'(counter_val14), 32'h0);
    checkOutput("async_ctrl", 32'(cntr_ctrl_out14), 32'h1);
    checkOutput("async_pulses", 32'(dut_pulses()), 32'h0);
    model_reset();
    @(posedge pclk14);
    #1 n_p_reset14 = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1, 16'h0);
    checkOutput("async_release_quiet", 32'(dut_pulses()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic applyStimulusIdle();
    cntr_ctrl_reg_sel14 = 1'b0;
    interval_reg_sel14  = 1'b0;
    match_1_reg_sel14   = 1'b0;
    match_2_reg_sel14   = 1'b0;
    match_3_reg_sel14   = 1'b0;
    clk_ctrl_en14       = 1'b0;
    pwdata14            = 16'h0;
  endtask

endmodule
